// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        R_WB      = 4'd3,
        EXEC_I    = 4'd4,
        I_WB      = 4'd5,
        MEM_ADDR  = 4'd6,
        MEM_READ  = 4'd7,
        MEM_WB    = 4'd8,
        MEM_WRITE = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11,
        JAL       = 4'd12,
        JR        = 4'd13,
        ERR       = 4'd14
    } stateT;

    // Opcodes (IR[31:26]) and the jr function code (IR[5:0])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_LUI   = 3'b100;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    // Datapath mux selects
    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    // State that follows DECODE for a given instruction
    function automatic stateT decodeOp(input logic [5:0] op, input logic [5:0] funct);
        stateT s;
        case (op)
            OP_RTYPE:                       s = (funct == FUNCT_JR) ? JR : EXEC_R;
            OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: s = EXEC_I;
            OP_LW, OP_SW:                   s = MEM_ADDR;
            OP_BEQ, OP_BNE:                 s = BRANCH;
            OP_J:                           s = JUMP;
            OP_JAL:                         s = JAL;
            default:                        s = ERR;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for a multicycle MIPS datapath with a shared,
// handshaked memory, a sticky illegal-opcode flag and a retire counter.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 branch_eq,
    output logic                 branch_ne,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic                 illegal_op,
    output logic [3:0]           state_out,
    output logic [CNT_WIDTH-1:0] instr_retired
);

    stateT                state;
    stateT                nextState;
    logic                 illegalFlag;
    logic [CNT_WIDTH-1:0] retiredCnt;

    assign state_out     = state;
    assign illegal_op    = illegalFlag;
    assign instr_retired = retiredCnt;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= nextState;
    end

    // Next-state selection, stalling on the memory handshake
    always_comb begin
        nextState = state;
        case (state)
            FETCH:     nextState = mem_ready ? DECODE : FETCH;
            DECODE:    nextState = decodeOp(op, funct);
            EXEC_R:    nextState = R_WB;
            EXEC_I:    nextState = I_WB;
            MEM_ADDR:  nextState = (op == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  nextState = mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: nextState = mem_ready ? FETCH : MEM_WRITE;
            R_WB, I_WB, MEM_WB, BRANCH, JUMP, JAL, JR: nextState = FETCH;
            ERR:       nextState = ERR;
            default:   nextState = FETCH;
        endcase
    end

    // Sticky illegal flag and retire counter; ERR never returns to FETCH so it cannot retire
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegalFlag <= 1'b0;
            retiredCnt  <= '0;
        end else begin
            if (nextState == ERR) illegalFlag <= 1'b1;
            if (state != FETCH && nextState == FETCH) retiredCnt <= retiredCnt + CNT_WIDTH'(1);
        end
    end

    // Output decode from state; everything is forced low while reset is held
    always_comb begin
        pc_write   = 1'b0;
        branch_eq  = 1'b0;
        branch_ne  = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = REG_DST_RT;
        mem_to_reg = M2R_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        pc_source  = PCSRC_ALU;
        if (reset) begin
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: alu_src_b = SRCB_IMM_SH2;
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_RTYPE;
                end
                R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = REG_DST_RD;
                end
                EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    case (op)
                        OP_ORI:  alu_op = ALU_OR;
                        OP_ANDI: alu_op = ALU_AND;
                        OP_LUI:  alu_op = ALU_LUI;
                        default: alu_op = ALU_ADD;
                    endcase
                end
                I_WB: reg_write = 1'b1;
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_MDR;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_source = PCSRC_ALUOUT;
                    branch_eq = (op == OP_BEQ);
                    branch_ne = (op == OP_BNE);
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                end
                JAL: begin
                    pc_write   = 1'b1;
                    pc_source  = PCSRC_JUMP;
                    reg_write  = 1'b1;
                    reg_dst    = REG_DST_RA;
                    mem_to_reg = M2R_PC;
                end
                JR: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_REG;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: each stimulus cycle queues its hand-computed expected
// outputs; the monitor pops and compares on the falling edge.
module tb_multicycle_control_fsm;
    import mips_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        mem_ready;
    logic        pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write;
    logic        ir_write, reg_write, alu_src_a, illegal_op;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [2:0]  alu_op;
    logic [3:0]  state_out;
    logic [31:0] instr_retired;

    multicycle_control_fsm #(.CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .branch_eq(branch_eq), .branch_ne(branch_ne),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
        .state_out(state_out), .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    // Control word: pcW beq bne iorD mRd mWr irW rgW | regDst | m2r | srcA | srcB | aluOp | pcSrc
    localparam logic [19:0] C_ZERO       = 20'b0000_0000_00_00_0_00_000_00;
    localparam logic [19:0] C_FETCH_RDY  = 20'b1000_1010_00_00_0_01_000_00;
    localparam logic [19:0] C_FETCH_WAIT = 20'b0000_1000_00_00_0_01_000_00;
    localparam logic [19:0] C_DECODE     = 20'b0000_0000_00_00_0_11_000_00;
    localparam logic [19:0] C_EXEC_ADD   = 20'b0000_0000_00_00_1_10_000_00;
    localparam logic [19:0] C_EXEC_ORI   = 20'b0000_0000_00_00_1_10_010_00;
    localparam logic [19:0] C_I_WB       = 20'b0000_0001_00_00_0_00_000_00;
    localparam logic [19:0] C_EXEC_R     = 20'b0000_0000_00_00_1_00_111_00;
    localparam logic [19:0] C_R_WB       = 20'b0000_0001_01_00_0_00_000_00;
    localparam logic [19:0] C_MEM_READ   = 20'b0001_1000_00_00_0_00_000_00;
    localparam logic [19:0] C_MEM_WB     = 20'b0000_0001_00_01_0_00_000_00;
    localparam logic [19:0] C_MEM_WRITE  = 20'b0001_0100_00_00_0_00_000_00;
    localparam logic [19:0] C_BEQ        = 20'b0100_0000_00_00_1_00_001_01;
    localparam logic [19:0] C_BNE        = 20'b0010_0000_00_00_1_00_001_01;
    localparam logic [19:0] C_JAL        = 20'b1000_0001_10_10_0_00_000_10;
    localparam logic [19:0] C_JR         = 20'b1000_0000_00_00_0_00_000_11;

    logic [19:0] actCtl;
    assign actCtl = {pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                     reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};

    typedef struct {
        string       label;
        logic [3:0]  st;
        logic [19:0] ctl;
        logic        ill;
        logic [31:0] ret;
    } expT;

    expT sb[$];
    int  total = 0;
    int  bad   = 0;

    // One clock cycle of stimulus plus the outputs expected during that cycle
    task automatic cyc(input string lbl, input logic rst, input logic [5:0] o,
                       input logic [5:0] f, input logic mr, input stateT st,
                       input logic [19:0] c, input logic ill, input logic [31:0] r);
        expT e;
        @(posedge clk);
        #1;
        reset = rst; op = o; funct = f; mem_ready = mr;
        e.label = lbl; e.st = st; e.ctl = c; e.ill = ill; e.ret = r;
        sb.push_back(e);
    endtask

    // Monitor: every cycle with a queued expectation is checked mid-cycle
    expT m;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m = sb.pop_front();
            total++;
            if (state_out !== m.st) begin
                bad++;
                $display("FAIL %s state got=%0d want=%0d", m.label, state_out, m.st);
            end
            total++;
            if (actCtl !== m.ctl) begin
                bad++;
                $display("FAIL %s ctl got=%b want=%b", m.label, actCtl, m.ctl);
            end
            total++;
            if (illegal_op !== m.ill) begin
                bad++;
                $display("FAIL %s illegal got=%b want=%b", m.label, illegal_op, m.ill);
            end
            total++;
            if (instr_retired !== m.ret) begin
                bad++;
                $display("FAIL %s retired got=%0d want=%0d", m.label, instr_retired, m.ret);
            end
        end
    end

    initial begin
        reset = 1'b0; op = '0; funct = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        cyc("rst_hold", 0, OP_ADDI, 6'h00, 1, FETCH, C_ZERO, 0, 0);

        // addi
        cyc("addi_f",  1, OP_ADDI, 6'h00, 1, FETCH,  C_FETCH_RDY, 0, 0);
        cyc("addi_d",  1, OP_ADDI, 6'h00, 1, DECODE, C_DECODE,    0, 0);
        cyc("addi_x",  1, OP_ADDI, 6'h00, 1, EXEC_I, C_EXEC_ADD,  0, 0);
        cyc("addi_wb", 1, OP_ADDI, 6'h00, 1, I_WB,   C_I_WB,      0, 0);

        // lw with two fetch waits and one read wait
        cyc("lw_f0",  1, OP_LW, 6'h00, 0, FETCH,    C_FETCH_WAIT, 0, 1);
        cyc("lw_f1",  1, OP_LW, 6'h00, 0, FETCH,    C_FETCH_WAIT, 0, 1);
        cyc("lw_f2",  1, OP_LW, 6'h00, 1, FETCH,    C_FETCH_RDY,  0, 1);
        cyc("lw_d",   1, OP_LW, 6'h00, 1, DECODE,   C_DECODE,     0, 1);
        cyc("lw_a",   1, OP_LW, 6'h00, 1, MEM_ADDR, C_EXEC_ADD,   0, 1);
        cyc("lw_r0",  1, OP_LW, 6'h00, 0, MEM_READ, C_MEM_READ,   0, 1);
        cyc("lw_r1",  1, OP_LW, 6'h00, 1, MEM_READ, C_MEM_READ,   0, 1);
        cyc("lw_wb",  1, OP_LW, 6'h00, 1, MEM_WB,   C_MEM_WB,     0, 1);

        // beq / bne
        cyc("beq_f", 1, OP_BEQ, 6'h00, 1, FETCH,  C_FETCH_RDY, 0, 2);
        cyc("beq_d", 1, OP_BEQ, 6'h00, 1, DECODE, C_DECODE,    0, 2);
        cyc("beq_b", 1, OP_BEQ, 6'h00, 1, BRANCH, C_BEQ,       0, 2);
        cyc("bne_f", 1, OP_BNE, 6'h00, 1, FETCH,  C_FETCH_RDY, 0, 3);
        cyc("bne_d", 1, OP_BNE, 6'h00, 1, DECODE, C_DECODE,    0, 3);
        cyc("bne_b", 1, OP_BNE, 6'h00, 1, BRANCH, C_BNE,       0, 3);

        // jal, then jr
        cyc("jal_f", 1, OP_JAL, 6'h00, 1, FETCH,  C_FETCH_RDY, 0, 4);
        cyc("jal_d", 1, OP_JAL, 6'h00, 1, DECODE, C_DECODE,    0, 4);
        cyc("jal_j", 1, OP_JAL, 6'h00, 1, JAL,    C_JAL,       0, 4);
        cyc("jr_f",  1, OP_RTYPE, FUNCT_JR, 1, FETCH,  C_FETCH_RDY, 0, 5);
        cyc("jr_d",  1, OP_RTYPE, FUNCT_JR, 1, DECODE, C_DECODE,    0, 5);
        cyc("jr_j",  1, OP_RTYPE, FUNCT_JR, 1, JR,     C_JR,        0, 5);

        // ori and an R-type add
        cyc("ori_f",  1, OP_ORI, 6'h00, 1, FETCH,  C_FETCH_RDY, 0, 6);
        cyc("ori_d",  1, OP_ORI, 6'h00, 1, DECODE, C_DECODE,    0, 6);
        cyc("ori_x",  1, OP_ORI, 6'h00, 1, EXEC_I, C_EXEC_ORI,  0, 6);
        cyc("ori_wb", 1, OP_ORI, 6'h00, 1, I_WB,   C_I_WB,      0, 6);
        cyc("add_f",  1, OP_RTYPE, 6'h20, 1, FETCH,  C_FETCH_RDY, 0, 7);
        cyc("add_d",  1, OP_RTYPE, 6'h20, 1, DECODE, C_DECODE,    0, 7);
        cyc("add_x",  1, OP_RTYPE, 6'h20, 1, EXEC_R, C_EXEC_R,    0, 7);
        cyc("add_wb", 1, OP_RTYPE, 6'h20, 1, R_WB,   C_R_WB,      0, 7);

        // sw completing normally
        cyc("sw_f", 1, OP_SW, 6'h00, 1, FETCH,     C_FETCH_RDY, 0, 8);
        cyc("sw_d", 1, OP_SW, 6'h00, 1, DECODE,    C_DECODE,    0, 8);
        cyc("sw_a", 1, OP_SW, 6'h00, 1, MEM_ADDR,  C_EXEC_ADD,  0, 8);
        cyc("sw_w", 1, OP_SW, 6'h00, 1, MEM_WRITE, C_MEM_WRITE, 0, 8);

        // illegal opcode: sticky flag, frozen counter
        cyc("ill_f", 1, 6'h3F, 6'h00, 1, FETCH,  C_FETCH_RDY, 0, 9);
        cyc("ill_d", 1, 6'h3F, 6'h00, 1, DECODE, C_DECODE,    0, 9);
        for (int i = 0; i < 20; i++)
            cyc("ill_err", 1, 6'h3F, 6'h00, 1, ERR, C_ZERO, 1, 9);

        // reset out of ERR
        cyc("err_rst", 0, OP_SW, 6'h00, 1, FETCH, C_ZERO, 0, 0);

        // reset while a store is stalled
        cyc("sw2_f",  1, OP_SW, 6'h00, 1, FETCH,     C_FETCH_RDY, 0, 0);
        cyc("sw2_d",  1, OP_SW, 6'h00, 1, DECODE,    C_DECODE,    0, 0);
        cyc("sw2_a",  1, OP_SW, 6'h00, 0, MEM_ADDR,  C_EXEC_ADD,  0, 0);
        cyc("sw2_w",  1, OP_SW, 6'h00, 0, MEM_WRITE, C_MEM_WRITE, 0, 0);
        cyc("sw2_rst", 0, OP_SW, 6'h00, 0, FETCH,    C_ZERO,      0, 0);
        cyc("sw2_rel", 1, OP_ADDI, 6'h00, 1, FETCH,  C_FETCH_RDY, 0, 0);

        @(posedge clk);
        #6;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Moore-style control sequencer that drives a multicycle MIPS datapath: one shared memory for instructions and data, a single ALU reused for PC+4, the branch target and execution, and IR/MDR/A/B/ALUOut holding registers. It decodes op/funct, emits every mux select and write strobe per state, and stalls on a memory ready handshake. It also flags illegal opcodes and counts retired instructions.

Parameters:
CNT_WIDTH, 32, width of the instr_retired counter (wraps modulo 2^CNT_WIDTH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
op  in  6  IR[31:26]
funct  in  6  IR[5:0]
mem_ready  in  1  shared memory completes the current access this cycle
pc_write  out  1  unconditional PC load
branch_eq  out  1  PC load if ALU Zero=1 (datapath gates)
branch_ne  out  1  PC load if ALU Zero=0 (datapath gates)
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
reg_write  out  1  register file write
reg_dst  out  2  00=rt, 01=rd, 10=$31
mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC (link)
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
alu_op  out  3  000 add, 001 sub, 010 or, 011 and, 100 lui, 111 R-type (funct-decoded)
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A (jr)
illegal_op  out  1  sticky illegal-opcode flag
state_out  out  4  current state encoding (debug)
instr_retired  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, illegal_op=0, instr_retired=0. Every strobe is 0 while reset is held. All selects are 0.
- Outputs are decoded from state only, except the handshake gating noted below. Selects not listed for a state are 0. Strobes not listed are 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00. ir_write and pc_write assert only in the cycle mem_ready=1. Stay in FETCH while mem_ready=0. Go to DECODE on mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut). Next state by op:
  - 0x00 with funct 0x08 -> JR; other 0x00 -> EXEC_R
  - 0x08/0x0D/0x0C/0x0F -> EXEC_I
  - 0x23/0x2B -> MEM_ADDR
  - 0x04/0x05 -> BRANCH
  - 0x02 -> JUMP; 0x03 -> JAL
  - any other op -> ERR
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=111 -> R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op = 000 (addi), 010 (ori), 011 (andi), 100 (lui) -> I_WB.
- I_WB: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000 -> MEM_READ if op=0x23, MEM_WRITE if op=0x2B.
- MEM_READ: mem_read=1, i_or_d=1. Hold while mem_ready=0, then -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold while mem_ready=0, then -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01. branch_eq=1 if op=0x04; branch_ne=1 if op=0x05 -> FETCH.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10 -> FETCH. The link value is PC+4, already loaded into PC during FETCH.
- JR: pc_write=1, pc_source=11 -> FETCH.
- ERR: all strobes 0, illegal_op=1. Terminal; exit only via reset.
- Latency with mem_ready tied high:
  - R-type, I-type, sw: 4 cycles
  - lw: 5 cycles
  - beq/bne, j, jal, jr: 3 cycles
  - Each memory wait cycle adds 1.
- instr_retired increments on every transition into FETCH from a non-FETCH state. It never increments from ERR. It wraps from all-ones to 0.
- Reset asserted mid-access (e.g. in MEM_WRITE) deasserts mem_write immediately. No partial state survives reset.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum: FETCH, DECODE, EXEC_R, R_WB, EXEC_I, I_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, JAL, JR, ERR (4-bit)
  - opcode constants and FUNCT_JR
  - alu_op codes
  - reg_dst, mem_to_reg, alu_src_b and pc_source select codes
- Single module with state register, next-state logic, output decode and counter. No sub-module.

Test Plan:
- Release reset, mem_ready=1, op=0x08 (addi): states FETCH, DECODE, EXEC_I, I_WB, FETCH. reg_write=1 only in I_WB with reg_dst=00 and mem_to_reg=00. instr_retired=1.
- op=0x23 (lw), mem_ready low for 2 cycles in FETCH and 1 cycle in MEM_READ:
  - ir_write/pc_write pulse once, on the third FETCH cycle
  - MEM_READ lasts 2 cycles, MEM_WB asserts mem_to_reg=01
  - 8 cycles total
- op=0x04 then op=0x05: 3 cycles each. BRANCH shows alu_op=001, pc_source=01. branch_eq=1 for op 0x04 and branch_ne=1 for op 0x05, never both.
- op=0x03 (jal): JAL cycle has pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10. Then op=0x00 with funct=0x08: JR has pc_source=11 and reg_write=0.
- op=0x3F: DECODE -> ERR. illegal_op=1 and stays sticky for 20 cycles. instr_retired stays frozen.
- Assert reset low while in MEM_WRITE: mem_write=0 immediately. After release: state=FETCH, illegal_op=0, instr_retired=0.
